// File: rtl/fan_pwm_driver.sv
// Fan motor actuator: PWM generation with whole-period duty updates, one-step
// duty ramping toward the commanded speed, and tach-based stall detect/retry.
module fan_pwm_driver #(
  parameter int PRESCALE      = 2,
  parameter int RAMP_PERIODS  = 4,
  parameter int STALL_PERIODS = 8,
  parameter int STALL_HOLD    = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] crs_i,
  input  logic       tach_i,
  output logic       pwm_o,
  output logic [3:0] duty_o,
  output logic       busy_o,
  output logic       stall_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = $clog2(RAMP_PERIODS + 1);
  localparam int SW = $clog2(STALL_PERIODS + 1);
  localparam int HW = $clog2(STALL_HOLD + 1);

  localparam logic [PW-1:0] PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [RW-1:0] RAMP_LIM  = RW'(RAMP_PERIODS);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_PERIODS);
  localparam logic [HW-1:0] HOLD_LIM  = HW'(STALL_HOLD);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RAMP  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_STALL = 2'd3;

  logic [PW-1:0] r_pre;
  logic [3:0]    r_slot;
  logic [3:0]    r_duty;
  logic [3:0]    r_target;
  logic [RW-1:0] r_ramp;
  logic [SW-1:0] r_stall;
  logic [HW-1:0] r_hold;
  logic [1:0]    r_state;
  logic          r_pwm;
  logic [1:0]    r_tach_s;
  logic          r_tach_q;

  logic          w_tick, w_pe, w_tach_edge;
  logic [RW-1:0] w_ramp_inc, w_ramp_nxt;
  logic          w_ramp_hit;
  logic [3:0]    w_duty_step, w_duty_nxt;
  logic          w_stall_clr, w_stall_hit;
  logic [SW-1:0] w_stall_inc, w_stall_nxt;
  logic [HW-1:0] w_hold_inc, w_hold_nxt;
  logic [1:0]    w_state_nxt;

  assign w_tick      = (r_pre == PRE_MAX);
  assign w_pe        = w_tick && (r_slot == 4'd15);
  assign w_tach_edge = r_tach_s[1] & ~r_tach_q;

  // Decisions at period_end use the value of crs_i being sampled into target.
  assign w_ramp_inc  = r_ramp + 1'b1;
  assign w_ramp_hit  = (r_duty != crs_i) && (w_ramp_inc == RAMP_LIM);
  assign w_duty_step = (crs_i > r_duty) ? r_duty + 4'd1 : r_duty - 4'd1;

  // A tach edge coinciding with period_end clears rather than counts.
  assign w_stall_clr = w_tach_edge || (r_duty == 4'd0) ||
                       !((r_state == S_RAMP) || (r_state == S_RUN));
  assign w_stall_inc = (r_stall == STALL_LIM) ? r_stall : r_stall + 1'b1;
  assign w_stall_nxt = w_stall_clr ? '0 : (w_pe ? w_stall_inc : r_stall);
  assign w_stall_hit = w_pe && !w_stall_clr && (w_stall_inc == STALL_LIM);

  assign w_hold_inc  = r_hold + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_ramp_nxt  = '0;
    w_hold_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        w_duty_nxt = '0;
        if (crs_i != 4'd0) w_state_nxt = S_RAMP;
      end
      S_RAMP: begin
        if (w_stall_hit) begin
          w_state_nxt = S_STALL;
          w_duty_nxt  = '0;
        end else begin
          if (w_ramp_hit)           w_duty_nxt = w_duty_step;
          else if (r_duty != crs_i) w_ramp_nxt = w_ramp_inc;
          if (w_duty_nxt == crs_i)
            w_state_nxt = (crs_i != 4'd0) ? S_RUN : S_IDLE;
        end
      end
      S_RUN: begin
        if (w_stall_hit) begin
          w_state_nxt = S_STALL;
          w_duty_nxt  = '0;
        end else if (crs_i != r_duty) begin
          w_state_nxt = S_RAMP;
        end
      end
      default: begin
        w_duty_nxt = '0;
        if (crs_i == 4'd0)            w_state_nxt = S_IDLE;
        else if (w_hold_inc == HOLD_LIM) w_state_nxt = S_RAMP;
        else                          w_hold_nxt  = w_hold_inc;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre    <= '0;
      r_slot   <= '0;
      r_duty   <= '0;
      r_target <= '0;
      r_ramp   <= '0;
      r_stall  <= '0;
      r_hold   <= '0;
      r_state  <= S_IDLE;
      r_pwm    <= 1'b0;
      r_tach_s <= '0;
      r_tach_q <= 1'b0;
    end else begin
      r_pre    <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_slot <= r_slot + 4'd1;
      r_tach_s <= {r_tach_s[0], tach_i};
      r_tach_q <= r_tach_s[1];
      r_pwm    <= (r_slot < r_duty) && (r_state != S_STALL);
      r_stall  <= w_stall_nxt;
      // Duty only moves at period_end so every PWM period is whole.
      if (w_pe) begin
        r_target <= crs_i;
        r_state  <= w_state_nxt;
        r_duty   <= w_duty_nxt;
        r_ramp   <= w_ramp_nxt;
        r_hold   <= w_hold_nxt;
      end
    end
  end

  assign pwm_o   = r_pwm;
  assign duty_o  = r_duty;
  assign stall_o = (r_state == S_STALL);
  assign busy_o  = (r_state == S_STALL) ? (r_target != 4'd0) : (r_duty != r_target);

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Directed bench for fan_pwm_driver: per-period vector table plus hand-built
// sequences for tach/period_end coincidence, stall exit and async reset.
module tb_fan_pwm_driver;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] crs_i = 4'd0;
  logic       tach_i = 1'b0;
  logic       pwm_o;
  logic [3:0] duty_o;
  logic       busy_o;
  logic       stall_o;

  int n_chk  = 0;
  int n_fail = 0;

  fan_pwm_driver #(
    .PRESCALE(2), .RAMP_PERIODS(1), .STALL_PERIODS(4), .STALL_HOLD(2)
  ) dut (
    .clk(clk), .rstn(rstn), .crs_i(crs_i), .tach_i(tach_i),
    .pwm_o(pwm_o), .duty_o(duty_o), .busy_o(busy_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // tmode: 0 no tach, 1 pulse mid-period, 2 edge lands on the period_end clk
  typedef struct {
    int crs;
    int tmode;
    int mid;
    int pwm_hi;
    int duty;
    int busy;
    int stall;
  } vec_t;

  vec_t tbl[28];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered #1 after a period_end edge; returns #1 after the next one.
  task automatic run_period(input int crs, input int tmode, input int mid, output int hi);
    logic [3:0] c;
    logic [3:0] m4;
    c = crs[3:0];
    m4 = mid[3:0];
    crs_i = c;
    tach_i = 1'b0;
    hi = 0;
    for (int m = 0; m < 32; m++) begin
      hi += int'(pwm_o);
      if (tmode == 1 && m == 8)  tach_i = 1'b1;
      if (tmode == 1 && m == 16) tach_i = 1'b0;
      if (tmode == 2 && m == 29) tach_i = 1'b1;
      if (mid >= 0 && m == 10) crs_i = m4;
      if (mid >= 0 && m == 20) crs_i = c;
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_outs(input string tag, input int d, input int b, input int s);
    chk($sformatf("%s duty", tag), int'(duty_o), d);
    chk($sformatf("%s busy", tag), int'(busy_o), b);
    chk($sformatf("%s stall", tag), int'(stall_o), s);
  endtask

  initial begin
    int hi;

    //            crs tm mid pwm d b s
    tbl[0]  = '{4, 1, -1,  0, 0, 1, 0};
    tbl[1]  = '{4, 1, -1,  0, 1, 1, 0};
    tbl[2]  = '{4, 1, -1,  2, 2, 1, 0};
    tbl[3]  = '{4, 1, -1,  4, 3, 1, 0};
    tbl[4]  = '{4, 1, -1,  6, 4, 0, 0};
    tbl[5]  = '{4, 1, -1,  8, 4, 0, 0};
    tbl[6]  = '{8, 1, -1,  8, 4, 1, 0};
    tbl[7]  = '{8, 1, -1,  8, 5, 1, 0};
    tbl[8]  = '{8, 1, -1, 10, 6, 1, 0};
    tbl[9]  = '{8, 1, -1, 12, 7, 1, 0};
    tbl[10] = '{8, 1, -1, 14, 8, 0, 0};
    tbl[11] = '{4, 1, -1, 16, 8, 1, 0};
    tbl[12] = '{4, 1, -1, 16, 7, 1, 0};
    tbl[13] = '{4, 1, -1, 14, 6, 1, 0};
    tbl[14] = '{4, 1, -1, 12, 5, 1, 0};
    tbl[15] = '{4, 1, -1, 10, 4, 0, 0};
    tbl[16] = '{4, 1,  9,  8, 4, 0, 0};
    tbl[17] = '{6, 0, -1,  8, 4, 1, 0};
    tbl[18] = '{6, 0, -1,  8, 5, 1, 0};
    tbl[19] = '{6, 0, -1, 10, 0, 1, 1};
    tbl[20] = '{6, 0, -1,  0, 0, 1, 1};
    tbl[21] = '{6, 0, -1,  0, 0, 1, 0};
    tbl[22] = '{6, 0, -1,  0, 1, 1, 0};
    tbl[23] = '{6, 1, -1,  2, 2, 1, 0};
    tbl[24] = '{6, 1, -1,  4, 3, 1, 0};
    tbl[25] = '{6, 1, -1,  6, 4, 1, 0};
    tbl[26] = '{6, 1, -1,  8, 5, 1, 0};
    tbl[27] = '{6, 1, -1, 10, 6, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset pwm", int'(pwm_o), 0);
    chk_outs("reset", 0, 0, 0);
    rstn = 1'b1;

    for (int i = 0; i < 28; i++) begin
      run_period(tbl[i].crs, tbl[i].tmode, tbl[i].mid, hi);
      chk($sformatf("vec%0d pwm_hi", i), hi, tbl[i].pwm_hi);
      chk_outs($sformatf("vec%0d", i), tbl[i].duty, tbl[i].busy, tbl[i].stall);
    end

    // RUN at 6, tach stops: count 2,3, then an edge on the period_end clk.
    run_period(6, 0, -1, hi);
    run_period(6, 0, -1, hi);
    run_period(6, 2, -1, hi);
    chk_outs("coincident edge", 6, 0, 0);
    run_period(6, 0, -1, hi);
    run_period(6, 0, -1, hi);
    run_period(6, 0, -1, hi);
    chk_outs("restart count 3", 6, 0, 0);
    run_period(6, 0, -1, hi);
    chk_outs("restart count 4", 0, 1, 1);

    // One held period, then crs 0 on the retry period_end wins -> IDLE.
    run_period(6, 0, -1, hi);
    chk("stall hold pwm_hi", hi, 0);
    chk_outs("stall hold", 0, 1, 1);
    run_period(0, 0, -1, hi);
    chk_outs("stall exit", 0, 0, 0);
    chk("stall exit pwm", int'(pwm_o), 0);

    // Ramp to duty 3, then async reset in the middle of a high pulse.
    run_period(4, 1, -1, hi);
    chk_outs("ramp2 start", 0, 1, 0);
    run_period(4, 1, -1, hi);
    run_period(4, 1, -1, hi);
    run_period(4, 1, -1, hi);
    chk_outs("ramp2 d3", 3, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset pwm", int'(pwm_o), 1);
    #1;
    rstn = 1'b0;
    #1;
    chk("async reset pwm", int'(pwm_o), 0);
    chk_outs("async reset", 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    crs_i = 4'd0;
    repeat (4) @(posedge clk);
    #1;
    chk("post-reset pwm", int'(pwm_o), 0);
    chk_outs("post-reset", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
